// File: rtl/adj_list_streamer.sv
// adj_list_streamer: expands one node of an adjacency list into a stream of
// successor indices. A node table holds {base, degree} per node and an edge
// table holds successor indices; both are loaded through the cfg write port
// while the streamer is idle.
//
// Optional build macro: ADJ_BOUNDS_CHECK_EN
//   defined   -> a node whose edge span runs past the end of the edge table
//                raises the sticky err flag and streams nothing
//   undefined -> no check, err is tied low, edge addresses wrap
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | ready for a request and for table writes
// S_LOOKUP | node entry read back; decide empty / error / start streaming
// S_STREAM | presenting edges, one per out_valid && out_ready handshake
module adj_list_streamer #(
  parameter int NODE_IDX_WIDTH  = 10,
  parameter int COUNTER_WIDTH   = 4,
  parameter int EDGE_ADDR_WIDTH = 12
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_wr_en,
  input  logic                                     cfg_wr_sel,
  input  logic [((NODE_IDX_WIDTH > EDGE_ADDR_WIDTH) ?
                 NODE_IDX_WIDTH : EDGE_ADDR_WIDTH)-1:0] cfg_wr_addr,
  input  logic [EDGE_ADDR_WIDTH+COUNTER_WIDTH-1:0] cfg_wr_data,
  output logic                                     cfg_ready,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [NODE_IDX_WIDTH-1:0]                node_idx,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NODE_IDX_WIDTH-1:0]                next_node_idx,
  output logic [COUNTER_WIDTH-1:0]                 next_node_counter,
  output logic                                     resp_empty,
  output logic                                     err
);

  localparam int NODE_DEPTH = 1 << NODE_IDX_WIDTH;
  localparam int EDGE_DEPTH = 1 << EDGE_ADDR_WIDTH;
  localparam int NODE_W     = EDGE_ADDR_WIDTH + COUNTER_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_STREAM} state_t;

  state_t                       state_q;
  logic [NODE_W-1:0]            node_mem [NODE_DEPTH];
  logic [NODE_IDX_WIDTH-1:0]    edge_mem [EDGE_DEPTH];

  logic [EDGE_ADDR_WIDTH-1:0]   lk_base_q;
  logic [COUNTER_WIDTH-1:0]     lk_deg_q;
  logic [EDGE_ADDR_WIDTH-1:0]   addr_q;
  logic [COUNTER_WIDTH-1:0]     cnt_q;
  logic [NODE_IDX_WIDTH-1:0]    edge_q;
  logic                         out_valid_q;
  logic                         resp_empty_q;

  logic                         idle;
  logic                         cfg_we;
  logic [NODE_W-1:0]            node_rd;
  logic [EDGE_ADDR_WIDTH-1:0]   addr_inc;
  logic                         bounds_bad;

  assign idle     = (state_q == S_IDLE);
  assign cfg_we   = cfg_wr_en && idle;
  assign node_rd  = node_mem[node_idx];
  assign addr_inc = addr_q + EDGE_ADDR_WIDTH'(1);

`ifdef ADJ_BOUNDS_CHECK_EN
  logic                         err_q;
  logic [EDGE_ADDR_WIDTH:0]     span_end;

  // One extra bit so a span ending exactly at the table end is not flagged.
  assign span_end   = {1'b0, lk_base_q} + (EDGE_ADDR_WIDTH+1)'(lk_deg_q);
  assign bounds_bad = span_end > (EDGE_ADDR_WIDTH+1)'(EDGE_DEPTH);
  assign err        = err_q;
`else
  assign bounds_bad = 1'b0;
  assign err        = 1'b0;
`endif

  assign cfg_ready         = idle;
  assign req_ready         = idle;
  assign out_valid         = out_valid_q;
  assign next_node_idx     = edge_q;
  assign next_node_counter = cnt_q;
  assign resp_empty        = resp_empty_q;

  // Table writes; accepted only while idle so an in-flight stream never sees a change.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      if (!cfg_wr_sel) begin
        node_mem[cfg_wr_addr[NODE_IDX_WIDTH-1:0]] <= cfg_wr_data;
      end else begin
        edge_mem[cfg_wr_addr[EDGE_ADDR_WIDTH-1:0]] <= cfg_wr_data[NODE_IDX_WIDTH-1:0];
      end
    end
  end

  // Streamer FSM with registered outputs; resp_empty is computed at request
  // acceptance so it is already a flop output during the LOOKUP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lk_base_q    <= '0;
      lk_deg_q     <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      edge_q       <= '0;
      out_valid_q  <= 1'b0;
      resp_empty_q <= 1'b0;
`ifdef ADJ_BOUNDS_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      resp_empty_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            lk_base_q    <= node_rd[NODE_W-1:COUNTER_WIDTH];
            lk_deg_q     <= node_rd[COUNTER_WIDTH-1:0];
            resp_empty_q <= (node_rd[COUNTER_WIDTH-1:0] == '0);
            state_q      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lk_deg_q == '0) begin
            state_q <= S_IDLE;
          end else if (bounds_bad) begin
`ifdef ADJ_BOUNDS_CHECK_EN
            err_q   <= 1'b1;
`endif
            state_q <= S_IDLE;
          end else begin
            addr_q      <= lk_base_q;
            cnt_q       <= lk_deg_q;
            edge_q      <= edge_mem[lk_base_q];
            out_valid_q <= 1'b1;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            cnt_q <= cnt_q - COUNTER_WIDTH'(1);
            if (cnt_q == COUNTER_WIDTH'(1)) begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              addr_q <= addr_inc;
              edge_q <= edge_mem[addr_inc];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adj_list_streamer.md
ADJ_LIST_STREAMER -- requirements
Module: adj_list_streamer

Interface
REQ-001 Parameter NODE_IDX_WIDTH, default 10, sets the node index width; the node table holds 2**NODE_IDX_WIDTH entries.
REQ-002 Parameter COUNTER_WIDTH, default 4, sets the out-degree width; maximum degree is 2**COUNTER_WIDTH-1.
REQ-003 Parameter EDGE_ADDR_WIDTH, default 12, sets the edge-table address width; the edge table holds 2**EDGE_ADDR_WIDTH entries.
REQ-004 Ports, one per line:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_en  in  1  table write strobe
- cfg_wr_sel  in  1  0 = node table, 1 = edge table
- cfg_wr_addr  in  max(NODE_IDX_WIDTH,EDGE_ADDR_WIDTH)  write address, low bits used per table
- cfg_wr_data  in  EDGE_ADDR_WIDTH+COUNTER_WIDTH  node entry {base,degree}; edge entry uses low NODE_IDX_WIDTH bits
- cfg_ready  out  1  high when writes are accepted
- req_valid  in  1  lookup request
- req_ready  out  1  streamer idle, request accepted
- node_idx  in  NODE_IDX_WIDTH  node to expand
- out_valid  out  1  next_node_idx/next_node_counter valid
- out_ready  in  1  consumer takes current edge
- next_node_idx  out  NODE_IDX_WIDTH  successor node
- next_node_counter  out  COUNTER_WIDTH  edges remaining including current; 1 = last
- resp_empty  out  1  one-cycle pulse: requested node has degree 0
- err  out  1  sticky error flag (see REQ-020)

Function
REQ-005 FSM states IDLE, LOOKUP, STREAM; encoding free.
REQ-006 IDLE: req_ready=1, cfg_ready=1; req_valid in cycle T latches node_idx, issues a synchronous node-table read, moves to LOOKUP.
REQ-007 Writes with cfg_wr_en=1 while cfg_ready=0 are dropped with no table change.
REQ-008 LOOKUP (T+1): node entry {base,degree} available; degree==0 -> resp_empty=1 for this cycle, return to IDLE (req_ready=1 at T+2).
REQ-009 LOOKUP, degree!=0: issue edge-table read at base, load remaining count=degree, move to STREAM.
REQ-010 STREAM: out_valid=1 from T+2; next_node_idx=edge[addr], next_node_counter=remaining.
REQ-011 out_valid&&out_ready: addr+1, remaining-1, next edge presented on the following cycle, sustaining one edge per cycle while out_ready is held high.
REQ-012 out_ready=0: next_node_idx and next_node_counter held stable, out_valid stays 1.
REQ-013 Handshake with next_node_counter==1: out_valid=0 next cycle, return to IDLE.
REQ-014 Edge address arithmetic is EDGE_ADDR_WIDTH bits, wrapping modulo 2**EDGE_ADDR_WIDTH (unless REQ-020 applies).
REQ-015 req_valid outside IDLE is ignored; the requester holds it until req_ready.
REQ-016 resp_empty and out_valid are never high in the same cycle.

Reset
REQ-017 rst_n low forces IDLE; out_valid=0, resp_empty=0, err=0, next_node_idx=0, next_node_counter=0, req_ready=1 and cfg_ready=1 after release.
REQ-018 Reset mid-stream abandons the stream; no further out_valid until a new request.
REQ-019 Table contents are not reset; they must be reloaded before use.

Configuration
REQ-020 ADJ_BOUNDS_CHECK_EN defined: in LOOKUP, base+degree > 2**EDGE_ADDR_WIDTH sets err (sticky until reset), streams nothing, returns to IDLE. Undefined: no check, err tied 0, addresses wrap per REQ-014.

Verification
REQ-021 Node 5 = {base 100, degree 3}, edges 100..102 = 7,8,9; request 5, out_ready=1 -> out_valid T+2..T+4 with (7,3),(8,2),(9,1); req_ready=1 at T+5.
REQ-022 Same setup, out_ready low 2 cycles after first beat -> (7,3) held 3 cycles, sequence unchanged, no drop or duplicate.
REQ-023 Node 6 degree 0 -> resp_empty single pulse at T+1, no out_valid, req_ready at T+2.
REQ-024 cfg write during STREAM -> table unchanged, readback by a later request returns the old value.
REQ-025 rst_n low during the second beat of REQ-021 -> out_valid=0 immediately; new request to node 5 streams (7,3) again.
REQ-026 ADJ_BOUNDS_CHECK_EN defined, node {base 4094, degree 3} -> err=1, no out_valid; undefined -> edges 4094,4095,0 streamed.
